// File: rtl/witf_scoreboard_pkg.sv
// Shared definitions for the write-in-flight scoreboard: register index width,
// default depth and the table entry layout.
package witf_scoreboard_pkg;

  localparam int unsigned REG_ADDR_W = 5;
  localparam int unsigned WITF_DEPTH = 4;

  typedef struct packed {
    logic                  valid;
    logic [REG_ADDR_W-1:0] rd;
  } witf_entry_t;

endpackage

// File: rtl/witf_scoreboard_if.sv
// IDU/EXU/WBU-facing signal bundle of the write-in-flight scoreboard.
interface witf_scoreboard_if
  import witf_scoreboard_pkg::*;
#(
  parameter int unsigned DEPTH = WITF_DEPTH,
  parameter int unsigned RAW_W = REG_ADDR_W
);
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  logic             disp_en;
  logic [RAW_W-1:0] disp_rd;
  logic [RAW_W-1:0] rs1;
  logic [RAW_W-1:0] rs2;
  logic             isRAW;
  logic             witf_full;
  logic             wb_en;
  logic [RAW_W-1:0] wb_rd;
  logic             flush_pipeline;
  logic             squash_youngest;
  logic [CNT_W-1:0] count;
  logic             witf_err;

  modport master (
    output disp_en, disp_rd, rs1, rs2, wb_en, wb_rd, flush_pipeline, squash_youngest,
    input  isRAW, witf_full, count, witf_err
  );

  modport slave (
    input  disp_en, disp_rd, rs1, rs2, wb_en, wb_rd, flush_pipeline, squash_youngest,
    output isRAW, witf_full, count, witf_err
  );

endinterface

// File: rtl/witf_scoreboard_match.sv
// witf_match: per-entry source/destination comparator with OR-reduce giving the
// RAW hazard flag. Register x0 never hazards.
module witf_match
  import witf_scoreboard_pkg::*;
#(
  parameter int unsigned DEPTH = WITF_DEPTH
) (
  input  witf_entry_t [DEPTH-1:0] entries,
  input  logic [DEPTH-1:0]        excl,
  input  logic [REG_ADDR_W-1:0]   rs1,
  input  logic [REG_ADDR_W-1:0]   rs2,
  output logic                    hit
);

  always_comb begin
    hit = 1'b0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (entries[i].valid && !excl[i] &&
          (((rs1 != '0) && (entries[i].rd == rs1)) ||
           ((rs2 != '0) && (entries[i].rd == rs2))))
        hit = 1'b1;
    end
  end

endmodule

// File: rtl/witf_scoreboard.sv
// Write-in-flight table: circular FIFO of pending destination registers with
// CAM lookup for RAW stalls. Define WITF_BYPASS_EN to hide a retiring head entry.
module witf_scoreboard
  import witf_scoreboard_pkg::*;
#(
  parameter int unsigned DEPTH = WITF_DEPTH,
  parameter int unsigned RAW_W = REG_ADDR_W
) (
  input logic               clk,
  input logic               rst,
  witf_scoreboard_if.slave  bus
);
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;
  localparam int unsigned IDX_W = CNT_W - 1;

  witf_entry_t [DEPTH-1:0] ent_q, ent_d;
  logic [CNT_W-1:0]        head_q, head_d;
  logic [CNT_W-1:0]        tail_q, tail_d;
  logic [CNT_W-1:0]        count_q, count_d;
  logic                    err_q, err_d;

  logic [CNT_W-1:0] tail_m1;
  logic [IDX_W-1:0] head_idx, tail_idx, tail_m1_idx;
  logic             full, empty;
  logic             push_req, push_ok, pop_ok, sq_req, sq_ok, pop_sq_last;
  logic [DEPTH-1:0] excl;

  always_comb begin
    tail_m1     = tail_q - CNT_W'(1);
    head_idx    = head_q[IDX_W-1:0];
    tail_idx    = tail_q[IDX_W-1:0];
    tail_m1_idx = tail_m1[IDX_W-1:0];
    full        = (head_q[CNT_W-1] != tail_q[CNT_W-1]) && (head_idx == tail_idx);
    empty       = (count_q == '0);

    push_req    = bus.disp_en && !bus.flush_pipeline && (bus.disp_rd != '0);
    pop_ok      = bus.wb_en && !empty;
    sq_req      = bus.flush_pipeline && bus.squash_youngest;
    // Pop and squash targeting the same sole entry: remove it once via the pop.
    pop_sq_last = pop_ok && sq_req && (count_q == CNT_W'(1));
    sq_ok       = sq_req && !empty && !pop_sq_last;
    push_ok     = push_req && (!full || pop_ok);
  end

  always_comb begin
    ent_d   = ent_q;
    head_d  = head_q + CNT_W'(pop_ok);
    tail_d  = tail_q + CNT_W'(push_ok) - CNT_W'(sq_ok);
    count_d = count_q + CNT_W'(push_ok) - CNT_W'(pop_ok) - CNT_W'(sq_ok);
    err_d   = err_q
            | (bus.wb_en && empty)
            | (pop_ok && (ent_q[head_idx].rd != bus.wb_rd))
            | (sq_req && empty)
            | (push_req && full && !pop_ok)
            | pop_sq_last;

    if (pop_ok) ent_d[head_idx].valid = 1'b0;
    if (sq_ok)  ent_d[tail_m1_idx].valid = 1'b0;
    // When full, tail aliases head: the push must win over the pop's clear.
    if (push_ok) begin
      ent_d[tail_idx].valid = 1'b1;
      ent_d[tail_idx].rd    = bus.disp_rd;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ent_q   <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      err_q   <= 1'b0;
    end else begin
      ent_q   <= ent_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    excl = '0;
`ifdef WITF_BYPASS_EN
    if (bus.wb_en && ent_q[head_idx].valid && (ent_q[head_idx].rd == bus.wb_rd))
      excl[head_idx] = 1'b1;
`endif
  end

  witf_match #(.DEPTH(DEPTH)) u_match (
    .entries (ent_q),
    .excl    (excl),
    .rs1     (bus.rs1),
    .rs2     (bus.rs2),
    .hit     (bus.isRAW)
  );

  assign bus.witf_full = (count_q == CNT_W'(DEPTH));
  assign bus.count     = count_q;
  assign bus.witf_err  = err_q;

endmodule

// File: tb/tb_witf_scoreboard.sv
// Directed and randomized checks of witf_scoreboard against a queue-based model.
module tb_witf_scoreboard;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned RAW_W = 5;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  witf_scoreboard_if #(.DEPTH(DEPTH), .RAW_W(RAW_W)) bus ();

  witf_scoreboard #(.DEPTH(DEPTH), .RAW_W(RAW_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int tests = 0;
  int fails = 0;
  int q[$];
  bit m_err = 1'b0;

`ifdef WITF_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  task automatic chk(input string tag, input int obs, input int exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic bit model_raw(input int r1, input int r2, input bit wb, input int wrd);
    for (int i = 0; i < q.size(); i++) begin
      if (BYPASS && i == 0 && wb && wrd == q[0]) continue;
      if ((r1 != 0 && q[i] == r1) || (r2 != 0 && q[i] == r2)) return 1'b1;
    end
    return 1'b0;
  endfunction

  task automatic model_step(input bit en, input int rd, input bit wb, input int wrd,
                            input bit fl, input bit sqy);
    int  cnt  = q.size();
    bit  push = en && !fl && rd != 0;
    bit  pop  = wb && cnt > 0;
    bit  sq   = fl && sqy;
    if (wb && cnt == 0) m_err = 1'b1;
    if (pop && wrd != q[0]) m_err = 1'b1;
    if (sq && cnt == 0) m_err = 1'b1;
    if (push && cnt == DEPTH && !pop) begin
      m_err = 1'b1;
      push  = 1'b0;
    end
    if (pop && sq && cnt == 1) begin
      void'(q.pop_front());
      m_err = 1'b1;
    end else begin
      if (pop) void'(q.pop_front());
      if (sq && cnt > 0) void'(q.pop_back());
    end
    if (push) q.push_back(rd);
  endtask

  task automatic do_cycle(input bit en, input int rd, input int r1, input int r2,
                          input bit wb, input int wrd, input bit fl, input bit sqy);
    @(negedge clk);
    bus.disp_en         = en;
    bus.disp_rd         = RAW_W'(rd);
    bus.rs1             = RAW_W'(r1);
    bus.rs2             = RAW_W'(r2);
    bus.wb_en           = wb;
    bus.wb_rd           = RAW_W'(wrd);
    bus.flush_pipeline  = fl;
    bus.squash_youngest = sqy;
    #1;
    chk("isRAW", int'(bus.isRAW), int'(model_raw(r1, r2, wb, wrd)));
    chk("count", int'(bus.count), q.size());
    chk("witf_full", int'(bus.witf_full), int'(q.size() == DEPTH));
    chk("witf_err", int'(bus.witf_err), int'(m_err));
    model_step(en, rd, wb, wrd, fl, sqy);
  endtask

  task automatic idle_inputs();
    bus.disp_en = 1'b0; bus.disp_rd = '0; bus.rs1 = '0; bus.rs2 = '0;
    bus.wb_en = 1'b0; bus.wb_rd = '0; bus.flush_pipeline = 1'b0; bus.squash_youngest = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    idle_inputs();
    rst = 1'b0;
    #2;
    q.delete();
    m_err = 1'b0;
    chk("rst_count", int'(bus.count), 0);
    chk("rst_err", int'(bus.witf_err), 0);
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    int rd, wrd;
    bit en, wb, fl, sqy;
    idle_inputs();
    #12;
    chk("reset_count", int'(bus.count), 0);
    chk("reset_raw", int'(bus.isRAW), 0);
    chk("reset_full", int'(bus.witf_full), 0);
    chk("reset_err", int'(bus.witf_err), 0);
    @(negedge clk);
    rst = 1'b1;

    // Fill to DEPTH, then overflow push.
    do_cycle(1, 5, 0, 0, 0, 0, 0, 0);
    do_cycle(1, 6, 0, 0, 0, 0, 0, 0);
    do_cycle(1, 7, 0, 0, 0, 0, 0, 0);
    do_cycle(1, 8, 0, 0, 0, 0, 0, 0);
    do_cycle(1, 9, 8, 5, 0, 0, 0, 0);
    do_cycle(0, 0, 9, 0, 0, 0, 0, 0);
    chk("ovf_count", int'(bus.count), 4);
    chk("ovf_full", int'(bus.witf_full), 1);
    chk("ovf_err", int'(bus.witf_err), 1);
    chk("ovf_rd9_absent", int'(bus.isRAW), 0);

    // Lookup on rs1/rs2 and writeback retirement.
    do_reset();
    do_cycle(1, 3, 3, 0, 0, 0, 0, 0);
    chk("push_not_yet_visible", int'(bus.isRAW), 0);
    do_cycle(0, 0, 3, 0, 0, 0, 0, 0);
    chk("rs1_hit", int'(bus.isRAW), 1);
    do_cycle(0, 0, 0, 0, 0, 0, 0, 0);
    do_cycle(0, 0, 0, 3, 0, 0, 0, 0);
    chk("rs2_hit", int'(bus.isRAW), 1);
    do_cycle(0, 0, 3, 0, 1, 3, 0, 0);
    chk("wb_cycle_raw", int'(bus.isRAW), BYPASS ? 0 : 1);
    do_cycle(0, 0, 3, 0, 0, 0, 0, 0);
    chk("after_wb_raw", int'(bus.isRAW), 0);
    chk("after_wb_count", int'(bus.count), 0);

    // Squash youngest with a concurrent (ignored) dispatch.
    do_reset();
    do_cycle(1, 4, 0, 0, 0, 0, 0, 0);
    do_cycle(1, 9, 0, 0, 0, 0, 0, 0);
    do_cycle(1, 11, 9, 0, 0, 0, 1, 1);
    do_cycle(0, 0, 9, 0, 0, 0, 0, 0);
    chk("squash_count", int'(bus.count), 1);
    chk("squash_rd9_gone", int'(bus.isRAW), 0);
    do_cycle(0, 0, 4, 11, 0, 0, 0, 0);
    chk("squash_rd4_kept", int'(bus.isRAW), 1);

    // Push+pop while full.
    do_reset();
    for (int i = 1; i <= 4; i++) do_cycle(1, i, 0, 0, 0, 0, 0, 0);
    do_cycle(1, 10, 0, 0, 1, 1, 0, 0);
    do_cycle(0, 0, 10, 0, 0, 0, 0, 0);
    chk("full_pp_count", int'(bus.count), 4);
    chk("full_pp_err", int'(bus.witf_err), 0);
    chk("full_pp_rd10", int'(bus.isRAW), 1);
    do_cycle(0, 0, 0, 0, 1, 2, 0, 0);
    do_cycle(0, 0, 0, 0, 1, 3, 0, 0);
    do_cycle(0, 0, 0, 0, 1, 4, 0, 0);
    do_cycle(0, 0, 10, 0, 1, 10, 0, 0);
    do_cycle(0, 0, 10, 0, 0, 0, 0, 0);
    chk("drain_err", int'(bus.witf_err), 0);

    // Pop+squash on the last entry, and pop/squash on empty.
    do_reset();
    do_cycle(1, 7, 0, 0, 0, 0, 0, 0);
    do_cycle(0, 0, 7, 0, 1, 7, 1, 1);
    do_cycle(0, 0, 7, 0, 0, 0, 0, 0);
    chk("popsq1_count", int'(bus.count), 0);
    chk("popsq1_err", int'(bus.witf_err), 1);
    do_reset();
    do_cycle(0, 0, 0, 0, 1, 0, 0, 0);
    do_cycle(0, 0, 0, 0, 0, 0, 1, 1);
    chk("empty_pop_err", int'(bus.witf_err), 1);

    // Asynchronous reset between edges with count=3 and err set.
    do_reset();
    do_cycle(1, 1, 0, 0, 0, 0, 0, 0);
    do_cycle(1, 2, 0, 0, 0, 0, 0, 0);
    do_cycle(1, 3, 0, 0, 0, 0, 0, 0);
    do_cycle(1, 5, 0, 0, 1, 9, 0, 0);
    do_cycle(0, 0, 1, 0, 0, 0, 0, 0);
    @(negedge clk);
    #2;
    rst = 1'b0;
    #1;
    chk("async_count", int'(bus.count), 0);
    chk("async_raw", int'(bus.isRAW), 0);
    chk("async_err", int'(bus.witf_err), 0);
    q.delete();
    m_err = 1'b0;
    @(negedge clk);
    rst = 1'b1;

    // Randomized traffic.
    for (int blk = 0; blk < 6; blk++) begin
      do_reset();
      for (int c = 0; c < 100; c++) begin
        en  = ($urandom_range(99) < 55);
        rd  = $urandom_range(7);
        wb  = ($urandom_range(99) < 35);
        wrd = (q.size() > 0 && $urandom_range(19) != 0) ? q[0] : $urandom_range(7);
        fl  = ($urandom_range(99) < 8);
        sqy = fl && ($urandom_range(1) == 1);
        do_cycle(en, rd, $urandom_range(7), $urandom_range(7), wb, wrd, fl, sqy);
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/witf_scoreboard.md
Name: witf_scoreboard

Overview:
- Write-in-flight table (WITF) for the in-order NPC pipeline.
- Records the destination register of every instruction dispatched from IDU that writes a register. Retires the entry when that instruction writes back.
- Drives the RAW stall (isRAW) and table-full (witf_full) signals into IDU. Drops the youngest entry when EXU flushes the pipeline.
- Circular FIFO of rd indices with combinational CAM-style lookup.

Parameters:
DEPTH, 4, number of in-flight entries; power of two, 2..16
RAW_W, 5, register index width
CNT_W, $clog2(DEPTH)+1, occupancy counter width (derived)

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-low
disp_en  in  1  push disp_rd (IDU already gates with RegWr, !flush, pipeline write enable, rd!=0)
disp_rd  in  RAW_W  destination register of the dispatched instruction
rs1  in  RAW_W  source 1 of the instruction currently in IDU
rs2  in  RAW_W  source 2 of the instruction currently in IDU
isRAW  out  1  combinational: rs1 or rs2 (non-zero) matches a valid entry
witf_full  out  1  count==DEPTH
wb_en  in  1  writeback of the oldest in-flight register write
wb_rd  in  RAW_W  rd being written back; must equal the head entry
flush_pipeline  in  1  EXU redirect
squash_youngest  in  1  with flush_pipeline: the ID/EX instruction being squashed holds an entry
count  out  CNT_W  current occupancy
witf_err  out  1  sticky protocol-error flag

Behaviour:
- Reset (rst=0, asynchronous): head=tail=0, all valid bits 0, count=0, witf_err=0. Outputs therefore: isRAW=0, witf_full=0.
- Storage: DEPTH entries of {valid, rd}. head/tail pointers are CNT_W bits wide (extra wrap bit). Index = ptr[CNT_W-2:0]. full when wrap bits differ and indices match.
- Push: disp_en=1, !flush_pipeline, not full.
  - Writes {1, disp_rd} at tail; tail+1 on the next edge.
  - disp_en while flush_pipeline is ignored.
  - disp_en while full: ignored, witf_err<=1.
  - disp_rd=0: ignored, no error.
- Pop: wb_en=1 with count>0.
  - Clears valid at head; head+1.
  - wb_rd!=head rd: entry still popped, witf_err<=1.
  - wb_en with count==0: ignored, witf_err<=1.
- Squash: flush_pipeline=1 with squash_youngest=1 and count>0.
  - Clears valid at tail-1; tail-1.
  - With count==0: ignored, witf_err<=1.
- Simultaneous events, one edge:
  - push+pop: count unchanged; legal when full.
  - pop+squash with count>=2: both applied, count-2.
  - pop+squash with count==1: entry removed once, count=0, witf_err<=1.
- Lookup: isRAW = OR over valid entries of ((rs1!=0 && rd==rs1) || (rs2!=0 && rd==rs2)). Purely combinational, zero latency, independent of disp_en in the same cycle.
  - A newly pushed entry is visible from the cycle after the push.
  - Duplicate rd entries are legal; each hits independently.
- witf_full reflects the registered count only. It does not anticipate a same-cycle pop; this is conservative by design.
- count wraps never. Increments/decrements are saturating-checked via the error rules above.
- witf_err clears only on reset.

Optional Feature:
- Macro: WITF_BYPASS_EN.
- Defined: the head entry is excluded from the isRAW match when wb_en=1 and wb_rd equals the head rd in the same cycle. Intended for a write-through register file, and saves one stall cycle. Younger duplicates of the same rd still hit.
- Undefined: every valid entry participates in the match, including the retiring one. RAW clears the cycle after writeback.

Decomposition:
- Shared package/defines: RegAddrBus width, WITF_DEPTH default, witf entry struct {valid, rd}.
- One natural sub-module: witf_match, the per-entry comparator plus OR-reduce producing isRAW, parameterised by DEPTH.
- Pointer/count logic stays in the top module.

Test Plan:
- Reset, then push rd=5,6,7,8 on consecutive cycles -> count=4, witf_full=1. A fifth push of rd=9 is ignored and witf_err=1.
- Push rd=3; next cycle rs1=3, rs2=0 -> isRAW=1. rs1=0, rs2=0 -> isRAW=0. rs2=3 -> isRAW=1.
- Push rd=3, then wb_en with wb_rd=3 -> count 1->0. isRAW for rs1=3 drops the cycle after writeback (macro off) or in the writeback cycle itself (macro on).
- Entries {4,9} present; flush_pipeline with squash_youngest=1 -> count=1, rs1=9 no longer hazards, rs1=4 still hazards. A concurrent disp_en is ignored.
- Full table (count=4) with simultaneous push rd=10 and wb_en of the head -> count stays 4, rd=10 at the new tail, witf_err=0.
- Assert rst low mid-sequence with count=3 (asynchronous, between edges) -> count=0, isRAW=0 immediately, witf_err=0.
